// File: rtl/hazard_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_controller                                          |
// | Description : Pipeline sequencing controller for the 5-stage MIPS core.  |
// |               Drives every latch enable and bubble flush for PC, IF/ID,  |
// |               ID/EX, EX/MEM and MEM/WB. Handles load-use stalls, imem    |
// |               and dmem wait states, taken-branch/jump redirects, halt.   |
// |               Optional macro HAZARD_PERF_EN adds the stall_cycles and    |
// |               flush_count performance counters.                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module hazard_controller #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TW             = 11
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_redirect,
  input  logic        mem_dreq,
  input  logic        dhit,
  input  logic        ihit,
  input  logic        mem_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        halted,
  output logic        mem_timeout,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEMWAIT  = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  // Control bundle layout: {pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f}
  localparam logic [7:0] c_CTL_NONE  = 8'b0000_0000;
  localparam logic [7:0] c_CTL_ALL   = 8'b1111_1000;
  localparam logic [7:0] c_CTL_REDIR = 8'b1111_1110;
  localparam logic [7:0] c_CTL_LU    = 8'b0011_1010;
  localparam logic [7:0] c_CTL_IMISS = 8'b0111_1100;
  // Wrong-path fetch draining: bubble into ID, PC advances only when the fetch lands
  localparam logic [6:0] c_CTL_DRAIN_LO = 7'b111_1100;

  localparam logic [TW-1:0] c_TIMEOUT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] c_ONE     = TW'(1);

  state_t          state_q;
  logic [TW-1:0]   cnt_q;
  logic [TW-1:0]   cnt_d;
  logic            pend_q;
  logic            timeout_q;
  logic            load_use;
  logic            dstall;
  logic [7:0]      ctl;

  // A load in EX feeding the ID instruction cannot be forwarded in time; r0 never hazards
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign dstall   = mem_dreq && !dhit;
  assign cnt_d    = (cnt_q == {TW{1'b1}}) ? cnt_q : cnt_q + c_ONE;

  // Select the enable/flush set from registered state plus this cycle's events
  always_comb begin
    ctl = c_CTL_NONE;
    unique case (state_q)
      ST_RUN: begin
        if (mem_halt || dstall) begin
          ctl = c_CTL_NONE;
        end else if (ex_redirect) begin
          ctl = c_CTL_REDIR;
        end else if (load_use) begin
          ctl = c_CTL_LU;
        end else if (!ihit) begin
          ctl = c_CTL_IMISS;
        end else begin
          ctl = c_CTL_ALL;
        end
      end
      ST_MEMWAIT: begin
        if (dhit) begin
          // A redirect interrupted by the dmem wait resumes draining its fetch
          if (pend_q) begin
            ctl = {ihit, c_CTL_DRAIN_LO};
          end else if (ex_redirect) begin
            ctl = c_CTL_REDIR;
          end else if (load_use) begin
            ctl = c_CTL_LU;
          end else begin
            ctl = c_CTL_ALL;
          end
        end
      end
      ST_REDIRECT: begin
        if (!(mem_halt || dstall)) begin
          ctl = {ihit, c_CTL_DRAIN_LO};
        end
      end
      ST_HALTED: begin
        ctl = c_CTL_NONE;
      end
    endcase
    // Everything is frozen while reset is held, independent of the clock
    if (!nRST) begin
      ctl = c_CTL_NONE;
    end
  end

  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
          ifid_flush, idex_flush, exmem_flush} = ctl;

  // Sequencer state, wait counter, deferred-redirect flag and sticky timeout
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_halt) begin
            state_q <= ST_HALTED;
          end else if (dstall) begin
            state_q <= ST_MEMWAIT;
            cnt_q   <= c_ONE;
            pend_q  <= 1'b0;
          end else if (ex_redirect && !ihit) begin
            state_q <= ST_REDIRECT;
          end
        end
        ST_MEMWAIT: begin
          cnt_q <= cnt_d;
          // Counter holds the number of the current wait cycle
          if (cnt_q >= c_TIMEOUT) begin
            timeout_q <= 1'b1;
          end
          if (dhit) begin
            pend_q <= 1'b0;
            if (pend_q) begin
              state_q <= ihit ? ST_RUN : ST_REDIRECT;
            end else if (ex_redirect && !ihit) begin
              state_q <= ST_REDIRECT;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_REDIRECT: begin
          if (mem_halt) begin
            state_q <= ST_HALTED;
          end else if (dstall) begin
            state_q <= ST_MEMWAIT;
            cnt_q   <= c_ONE;
            pend_q  <= 1'b1;
          end else if (ihit) begin
            state_q <= ST_RUN;
          end
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
        end
      endcase
    end
  end

  assign halted      = (state_q == ST_HALTED);
  assign mem_timeout = timeout_q;
  assign state_o     = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Performance counters; a redirect is the only ID/EX flush that lets the PC advance
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && !halted) begin
        stall_q <= stall_q + 32'd1;
      end
      if (idex_flush && pc_en) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hazard_controller                                       |
// | Description : Self-checking bench for hazard_controller: vector table,   |
// |               directed multi-cycle sequences and random stimulus against |
// |               a behavioural model. TIMEOUT_CYCLES is set to 8.           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_hazard_controller;

  localparam int TO = 8;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] exrd;
    logic       memread;
    logic       redir;
    logic       dreq;
    logic       dhit;
    logic       ihit;
    logic       halt;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [7:0] exp;
    logic [1:0] nxt;
  } vec_t;

  // Expected control sets: {pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f}
  localparam logic [7:0] E_NONE  = 8'b0000_0000;
  localparam logic [7:0] E_ALL   = 8'b1111_1000;
  localparam logic [7:0] E_REDIR = 8'b1111_1110;
  localparam logic [7:0] E_LU    = 8'b0011_1010;
  localparam logic [7:0] E_IMISS = 8'b0111_1100;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rt, ex_memread, ex_redirect, mem_dreq, dhit, ihit, mem_halt;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, halted, mem_timeout;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the controller's situation
  logic m_halt, m_wait, m_redir, m_pend, m_tout;
  int   m_waitcnt;
  int unsigned m_stall, m_flush;

  hazard_controller #(.TIMEOUT_CYCLES(TO), .TW(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mem_dreq(mem_dreq), .dhit(dhit), .ihit(ihit), .mem_halt(mem_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .halted(halted), .mem_timeout(mem_timeout),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .state_o(state_o)
  );

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush};

  always #5 CLK = ~CLK;

  function automatic in_t mk(input int rs, input int rt, input int ur, input int exrd,
                             input int mr, input int rd, input int dq, input int dh,
                             input int ih, input int hl);
    in_t r;
    r.rs = 5'(rs); r.rt = 5'(rt); r.uses_rt = 1'(ur); r.exrd = 5'(exrd);
    r.memread = 1'(mr); r.redir = 1'(rd); r.dreq = 1'(dq); r.dhit = 1'(dh);
    r.ihit = 1'(ih); r.halt = 1'(hl);
    return r;
  endfunction

  function automatic in_t idle();
    return mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  function automatic in_t rnd_in();
    in_t r;
    r.rs      = 5'($urandom_range(0, 3));
    r.rt      = 5'($urandom_range(0, 3));
    r.uses_rt = 1'($urandom_range(0, 1));
    r.exrd    = 5'($urandom_range(0, 3));
    r.memread = ($urandom_range(0, 9) < 3);
    r.redir   = ($urandom_range(0, 9) < 2);
    r.dreq    = ($urandom_range(0, 9) < 3);
    r.dhit    = ($urandom_range(0, 9) < 5);
    r.ihit    = ($urandom_range(0, 9) < 7);
    r.halt    = ($urandom_range(0, 199) == 0);
    return r;
  endfunction

  task automatic apply(input in_t in);
    id_rs = in.rs; id_rt = in.rt; id_uses_rt = in.uses_rt; ex_rd = in.exrd;
    ex_memread = in.memread; ex_redirect = in.redir; mem_dreq = in.dreq;
    dhit = in.dhit; ihit = in.ihit; mem_halt = in.halt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic load_use(input in_t in);
    return in.memread && (in.exrd != 5'd0) &&
           ((in.exrd == in.rs) || (in.uses_rt && (in.exrd == in.rt)));
  endfunction

  function automatic logic [1:0] m_state();
    if (m_halt) return 2'd3;
    if (m_wait) return 2'd1;
    if (m_redir) return 2'd2;
    return 2'd0;
  endfunction

  // Outputs by priority: halt > dmem wait > redirect > load-use > imem wait
  function automatic logic [7:0] exp_out(input in_t in);
    if (m_halt) return E_NONE;
    if (m_wait) begin
      if (!in.dhit) return E_NONE;
      if (m_pend) return {in.ihit, 7'b111_1100};
      if (in.redir) return E_REDIR;
      if (load_use(in)) return E_LU;
      return E_ALL;
    end
    if (in.halt || (in.dreq && !in.dhit)) return E_NONE;
    if (m_redir) return {in.ihit, 7'b111_1100};
    if (in.redir) return E_REDIR;
    if (load_use(in)) return E_LU;
    if (!in.ihit) return E_IMISS;
    return E_ALL;
  endfunction

  task automatic m_reset();
    m_halt = 0; m_wait = 0; m_redir = 0; m_pend = 0; m_tout = 0;
    m_waitcnt = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic m_step(input in_t in, input logic [7:0] e);
    if (!e[7] && !m_halt) m_stall++;
    if (e[1] && e[7]) m_flush++;
    if (m_halt) begin
      // frozen until reset
    end else if (m_wait) begin
      if (m_waitcnt >= TO) m_tout = 1;
      m_waitcnt++;
      if (in.dhit) begin
        m_wait = 0;
        m_redir = m_pend ? !in.ihit : (in.redir && !in.ihit);
        m_pend = 0;
      end
    end else if (in.halt) begin
      m_halt = 1; m_redir = 0;
    end else if (in.dreq && !in.dhit) begin
      m_wait = 1; m_waitcnt = 1; m_pend = m_redir; m_redir = 0;
    end else if (m_redir) begin
      if (in.ihit) m_redir = 0;
    end else if (in.redir && !in.ihit) begin
      m_redir = 1;
    end
  endtask

  // One clock: drive, check at the falling edge, advance the model at the rising edge
  task automatic cyc(input in_t in);
    logic [7:0] e;
    apply(in);
    @(negedge CLK);
    e = exp_out(in);
    chk("ctl", {24'd0, outs}, {24'd0, e});
    chk("state_o", {30'd0, state_o}, {30'd0, m_state()});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_tout});
`ifdef HAZARD_PERF_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
`endif
    @(posedge CLK);
    m_step(in, e);
    #1;
  endtask

  task automatic do_reset();
    apply(idle());
    nRST = 1'b0;
    m_reset();
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_ctl", {24'd0, outs}, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_flags", {30'd0, halted, mem_timeout}, 32'd0);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    in_t  lu5;

    // ---- single-cycle vectors from RUN --------------------------------------------
    //                     rs rt ur rd mr re dq dh ih hl
    tbl.push_back('{mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 0), E_ALL,   2'd0});
    tbl.push_back('{mk(5, 2, 0, 5, 1, 0, 0, 0, 1, 0), E_LU,    2'd0});
    tbl.push_back('{mk(0, 2, 0, 0, 1, 0, 0, 0, 1, 0), E_ALL,   2'd0});
    tbl.push_back('{mk(3, 7, 1, 7, 1, 0, 0, 0, 1, 0), E_LU,    2'd0});
    tbl.push_back('{mk(3, 7, 0, 7, 1, 0, 0, 0, 1, 0), E_ALL,   2'd0});
    tbl.push_back('{mk(5, 2, 0, 5, 0, 0, 0, 0, 1, 0), E_ALL,   2'd0});
    tbl.push_back('{mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0), E_IMISS, 2'd0});
    tbl.push_back('{mk(1, 2, 0, 0, 0, 1, 0, 0, 1, 0), E_REDIR, 2'd0});
    tbl.push_back('{mk(1, 2, 0, 0, 0, 1, 0, 0, 0, 0), E_REDIR, 2'd2});
    tbl.push_back('{mk(5, 2, 0, 5, 1, 1, 0, 0, 1, 0), E_REDIR, 2'd0});
    tbl.push_back('{mk(1, 2, 0, 0, 0, 0, 1, 0, 1, 0), E_NONE,  2'd1});
    tbl.push_back('{mk(1, 2, 0, 0, 0, 0, 1, 1, 1, 0), E_ALL,   2'd0});
    tbl.push_back('{mk(5, 2, 0, 5, 1, 1, 1, 0, 0, 1), E_NONE,  2'd3});
    tbl.push_back('{mk(1, 2, 0, 0, 0, 1, 1, 0, 1, 0), E_NONE,  2'd1});
    tbl.push_back('{mk(5, 2, 0, 5, 1, 0, 0, 0, 0, 0), E_LU,    2'd0});

    apply(idle());
    do_reset();
    foreach (tbl[i]) begin
      do_reset();
      apply(tbl[i].in);
      @(negedge CLK);
      chk($sformatf("vec%0d_ctl", i), {24'd0, outs}, {24'd0, tbl[i].exp});
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_next", i), {30'd0, state_o}, {30'd0, tbl[i].nxt});
    end

    // ---- load-use: exactly one bubble, then the bubble sits in EX ------------------
    do_reset();
    lu5 = mk(5, 2, 0, 5, 1, 0, 0, 0, 1, 0);
    cyc(lu5);
    apply(idle());
    @(negedge CLK);
    chk("lu_release_pc", {31'd0, pc_en}, 32'd1);
    @(posedge CLK); m_step(idle(), E_ALL); #1;
    cyc(mk(5, 2, 0, 0, 1, 0, 0, 0, 1, 0));

    // ---- dmem wait: four stalled cycles then dhit ----------------------------------
    do_reset();
    cyc(mk(1, 2, 0, 0, 0, 0, 1, 0, 1, 0));
    for (int k = 0; k < 4; k++) cyc(mk(1, 2, 0, 0, 0, 0, 1, 0, 1, 0));
    cyc(mk(1, 2, 0, 0, 0, 0, 1, 1, 1, 0));
    chk("mw_exit_state", {30'd0, state_o}, 32'd0);

    // ---- redirect with a three-cycle imem miss -------------------------------------
    do_reset();
    cyc(mk(1, 2, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) cyc(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(idle());
    chk("redir_exit_state", {30'd0, state_o}, 32'd0);

    // ---- dmem wait interrupting a redirect, then resume ----------------------------
    do_reset();
    cyc(mk(1, 2, 0, 0, 0, 1, 0, 0, 0, 0));
    cyc(mk(1, 2, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc(mk(1, 2, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc(mk(1, 2, 0, 0, 0, 0, 1, 1, 0, 0));
    chk("pend_reenter", {30'd0, state_o}, 32'd2);
    cyc(idle());
    cyc(idle());

    // ---- halt beats everything and sticks ------------------------------------------
    do_reset();
    cyc(mk(5, 2, 0, 5, 1, 1, 0, 0, 1, 1));
    for (int k = 0; k < 6; k++) cyc(rnd_in());
    chk("halt_sticky", {31'd0, halted}, 32'd1);

    // ---- memory timeout with dhit never arriving, then reset clears it -------------
    do_reset();
    cyc(mk(1, 2, 0, 0, 0, 0, 1, 0, 1, 0));
    for (int k = 0; k < 12; k++) cyc(mk(1, 2, 0, 0, 0, 0, 1, 0, 1, 0));
    chk("timeout_set", {31'd0, mem_timeout}, 32'd1);
    cyc(mk(1, 2, 0, 0, 0, 0, 1, 1, 1, 0));
    cyc(idle());
    chk("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
    do_reset();
    chk("timeout_cleared", {31'd0, mem_timeout}, 32'd0);

    // ---- asynchronous reset in the middle of a dmem wait ---------------------------
    cyc(mk(1, 2, 0, 0, 0, 0, 1, 0, 1, 0));
    cyc(mk(1, 2, 0, 0, 0, 0, 1, 0, 1, 0));
    nRST = 1'b0;
    #1;
    chk("async_rst_state", {30'd0, state_o}, 32'd0);
    chk("async_rst_ctl", {24'd0, outs}, 32'd0);
    do_reset();

`ifdef HAZARD_PERF_EN
    // ---- two load-use stalls and one redirect --------------------------------------
    do_reset();
    cyc(lu5); cyc(idle()); cyc(lu5); cyc(idle());
    cyc(mk(1, 2, 0, 0, 0, 1, 0, 0, 1, 0));
    cyc(idle());
    chk("perf_stall", stall_cycles, 32'd2);
    chk("perf_flush", flush_count, 32'd1);
`endif

    // ---- random stimulus against the model -----------------------------------------
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int k = 0; k < 120; k++) cyc(rnd_in());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
